// File: rtl/demux_1_4_stream_pkg.sv
// Shared types and sizes for the 1-to-4 stream demultiplexer.
//   N_OUT      : number of output channels
//   SEL_W      : width of the destination select
//   sel_t      : destination channel index
//   ch_state_e : per-channel holding register state (EMPTY/FULL == out_valid)
package demux_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/demux_1_4_stream_if.sv
// Bus bundle for demux_1_4_stream: one producer stream in, four consumer
// streams out, plus per-channel delivered-beat counters.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : demux side (drives in_ready, out_*, beat_cnt)
// Optional macro DEMUX_BCAST_EN adds the in_bcast input.
interface demux_1_4_stream_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);

  logic [WIDTH-1:0]       in_data;
  sel_t                   in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*CNT_W-1:0] beat_cnt;
`ifdef DEMUX_BCAST_EN
  logic                   in_bcast;
`endif

  modport master (
`ifdef DEMUX_BCAST_EN
    output in_bcast,
`endif
    output in_data,
    output in_sel,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  beat_cnt
  );

  modport slave (
`ifdef DEMUX_BCAST_EN
    input  in_bcast,
`endif
    input  in_data,
    input  in_sel,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output beat_cnt
  );

endinterface

// File: rtl/demux_1_4_stream_ch_reg.sv
// One output channel of the demux: a one-entry holding register with
// valid/ready handshake and a wrapping delivered-beat counter.
//   clk, rst   : clock, synchronous active-high reset
//   load       : an accepted input beat targets this channel
//   ld_data    : payload to capture on load
//   out_ready  : consumer accepts the held beat
//   out_valid  : holding register full
//   out_data   : held payload
//   beat_cnt   : number of delivered beats, modulo 2^CNT_W
module demux_ch_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] beat_cnt
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load wins over unload so a same-cycle refill has no bubble
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        if (out_ready) cnt_d = cnt_q + CNT_W'(1);
        if (!load && out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (load) data_d = ld_data;
  end

  // Outputs
  always_comb begin
    out_valid = (state_q == FULL);
    out_data  = data_q;
    beat_cnt  = cnt_q;
  end

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer. Each accepted input beat is
// written into the holding register of the channel chosen by in_sel;
// the input stalls only when that channel is full and not draining.
//   clk, rst : clock, synchronous active-high reset
//   bus      : demux_1_4_stream_if.slave (in_*, out_*, beat_cnt)
// Optional macro DEMUX_BCAST_EN: in_bcast=1 writes the beat to all four
// channels, accepted only when every channel can take it.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1_4_stream_if.slave    bus
);

  logic [N_OUT-1:0] ch_valid;
  logic [WIDTH-1:0] ch_data [N_OUT];
  logic [CNT_W-1:0] ch_cnt  [N_OUT];
  logic [N_OUT-1:0] free_c;
  logic [N_OUT-1:0] load_c;
  logic             bcast_c;
  logic             in_ready_c;
  logic             accept_c;

  // Acceptance and per-channel load decode
  always_comb begin
    bcast_c = 1'b0;
`ifdef DEMUX_BCAST_EN
    bcast_c = bus.in_bcast;
`endif
    free_c     = ~ch_valid | bus.out_ready;
    in_ready_c = bcast_c ? (&free_c) : free_c[bus.in_sel];
    accept_c   = bus.in_valid & in_ready_c;
    load_c     = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      load_c[k] = accept_c & ((bus.in_sel == sel_t'(k)) | bcast_c);
    end
  end

  for (genvar g = 0; g < int'(N_OUT); g++) begin : g_ch
    demux_ch_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c[g]),
      .ld_data   (bus.in_data),
      .out_ready (bus.out_ready[g]),
      .out_valid (ch_valid[g]),
      .out_data  (ch_data[g]),
      .beat_cnt  (ch_cnt[g])
    );
  end

  // Pack channel outputs onto the bus
  always_comb begin
    bus.in_ready  = in_ready_c;
    bus.out_valid = ch_valid;
    bus.out_data  = '0;
    bus.beat_cnt  = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = ch_data[k];
      bus.beat_cnt[k*CNT_W +: CNT_W] = ch_cnt[k];
    end
  end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed scenarios followed by
// random traffic, compared against a queue-based model of four one-deep
// channels with modulo delivery counters.
module tb_demux_1_4_stream;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
`ifdef DEMUX_BCAST_EN
  localparam bit BCAST_BUILD = 1'b1;
`else
  localparam bit BCAST_BUILD = 1'b0;
`endif

  logic clk;
  logic rst;

  demux_1_4_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux_1_4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: each channel is a queue holding at most one beat
  bit [WIDTH-1:0] mq [4][$];
  int             mcnt [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out_valid%0d", k), 32'(bus.out_valid[k]), 32'(mq[k].size() != 0));
      if (mq[k].size() != 0)
        check($sformatf("out_data%0d", k), 32'(bus.out_data[k*WIDTH +: WIDTH]), 32'(mq[k][0]));
      check($sformatf("beat_cnt%0d", k), 32'(bus.beat_cnt[k*CNT_W +: CNT_W]), 32'(mcnt[k]));
    end
  endtask

  // One clock of stimulus: drive, check in_ready, clock, update model, check outputs
  task automatic step(input bit v, input bit [1:0] s, input bit [WIDTH-1:0] d,
                      input bit [3:0] rdy, input bit b);
    bit bc;
    bit exp_rdy;
    bit acc;
    bc = b & BCAST_BUILD;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = rdy;
`ifdef DEMUX_BCAST_EN
    bus.in_bcast  = b;
`endif
    #1;
    if (bc) begin
      exp_rdy = 1'b1;
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && !rdy[k]) exp_rdy = 1'b0;
    end else begin
      exp_rdy = (mq[s].size() == 0) || rdy[s];
    end
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0 && rdy[k]) begin
        void'(mq[k].pop_front());
        mcnt[k] = (mcnt[k] + 1) % (1 << CNT_W);
      end
    end
    if (acc)
      for (int k = 0; k < 4; k++)
        if (bc || k == int'(s)) mq[k].push_back(d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_beat_cnt", 32'(bus.beat_cnt), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
`ifdef DEMUX_BCAST_EN
    bus.in_bcast  = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // One beat to each channel, all consumers ready
    step(1, 2'd0, 4'ha, 4'b1111, 0);
    step(1, 2'd1, 4'hb, 4'b1111, 0);
    step(1, 2'd2, 4'hc, 4'b1111, 0);
    step(1, 2'd3, 4'hd, 4'b1111, 0);
    step(0, 2'd0, 4'h0, 4'b1111, 0);
    check("t1_beat_cnt", 32'(bus.beat_cnt), 32'h01010101);

    // Blocked channel 2: second beat stalls, then enters with no bubble
    step(1, 2'd2, 4'h3, 4'b1011, 0);
    step(1, 2'd2, 4'h7, 4'b1011, 0);
    check("t2_hold_data", 32'(bus.out_data[2*WIDTH +: WIDTH]), 32'h3);
    step(1, 2'd2, 4'h7, 4'b1111, 0);
    check("t2_nobubble_valid", 32'(bus.out_valid[2]), 32'h1);
    check("t2_nobubble_data", 32'(bus.out_data[2*WIDTH +: WIDTH]), 32'h7);

    // Other channels flow while channel 2 is blocked
    step(1, 2'd0, 4'h7, 4'b1011, 0);
    step(1, 2'd1, 4'ha, 4'b1011, 0);
    step(0, 2'd0, 4'h0, 4'b1011, 0);
    check("t3_ch2_data", 32'(bus.out_data[2*WIDTH +: WIDTH]), 32'h7);
    check("t3_valid", 32'(bus.out_valid), 32'h4);

    // Reset discards held beats
    step(1, 2'd0, 4'h5, 4'b0000, 0);
    step(1, 2'd1, 4'h6, 4'b0000, 0);
    check("t5_loaded", 32'(bus.out_valid), 32'h7);
    do_reset();

    // Counter wrap on channel 3
    for (int i = 0; i < 256; i++)
      step(1, 2'd3, 4'($urandom), 4'b1111, 0);
    check("t4_cnt255", 32'(bus.beat_cnt[3*CNT_W +: CNT_W]), 32'd255);
    step(0, 2'd0, 4'h0, 4'b1111, 0);
    check("t4_wrap", 32'(bus.beat_cnt[3*CNT_W +: CNT_W]), 32'd0);

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for every channel, then loads all four
    step(1, 2'd1, 4'h9, 4'b0000, 0);
    step(1, 2'd0, 4'hd, 4'b0000, 1);
    check("bc_stall", 32'(bus.in_ready), 32'h0);
    step(1, 2'd0, 4'hd, 4'b0010, 1);
    check("bc_all_data", 32'(bus.out_data), 32'hdddd);
    check("bc_all_valid", 32'(bus.out_valid), 32'hf);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
           4'($urandom), bit'($urandom_range(0, 7) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
